// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and helpers shared by the timing generator.
package vga_timing_pkg;

    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W = 10;

    // Inclusive range test on a counter value.
    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_clk_en_div.sv
// Divides the system clock into a registered one-clk pixel-rate enable.
module vga_clk_en_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_en
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            clk_en  <= 1'b0;
        end else begin
            clk_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator with registered sync/video decodes.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clk_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             video_on,
    output logic             detect_neg_vsyncb
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    localparam int unsigned H_TOT      = H_BP + H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;

    generate
        if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 2) begin : g_bad_cfg
            $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;

    vga_clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en)
    );

    // Next-count values; decodes are taken from these so they track the counters.
    always_comb begin
        h_nxt = hcnt;
        v_nxt = vcnt;
        if (clk_en) begin
            if (hcnt == CNT_W'(H_TOT - 1)) begin
                h_nxt = '0;
                v_nxt = (vcnt == CNT_W'(V_TOT - 1)) ? '0 : vcnt + CNT_W'(1);
            end else begin
                h_nxt = hcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt              <= '0;
            vcnt              <= '0;
            hsync_n           <= 1'b1;
            vsync_n           <= 1'b1;
            video_on          <= 1'b0;
            detect_neg_vsyncb <= 1'b0;
        end else begin
            hcnt              <= h_nxt;
            vcnt              <= v_nxt;
            hsync_n           <= !in_range(h_nxt, CNT_W'(H_SYNC_BEG), CNT_W'(H_TOT - 1));
            vsync_n           <= !in_range(v_nxt, CNT_W'(V_SYNC_BEG),
                                           CNT_W'(V_SYNC_BEG + V_SYNC - 1));
            video_on          <= in_range(h_nxt, CNT_W'(H_BP), CNT_W'(H_BP + H_ACTIVE - 1))
                                 && (v_nxt < CNT_W'(V_ACTIVE));
            detect_neg_vsyncb <= (v_nxt == CNT_W'(V_SYNC_BEG)) && (h_nxt == '0);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Counts frame starts; the pulse spans exactly one clk_en so this steps once per frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (clk_en && detect_neg_vsyncb) begin
            frame_cnt <= frame_cnt + 8'(1);
        end
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream neighbour of the VGA pixel/address stage.
- Divides the system clock into a pixel-rate enable.
- Runs the horizontal and vertical counters, decodes hsync/vsync/video_on, and emits a one-pixel pulse at each vsync falling edge.
- The pixel stage consumes clk_en, hcnt, vcnt and detect_neg_vsyncb directly.
- Horizontal origin: hcnt=0 is the first back-porch pixel, so active video is hcnt H_BP..H_BP+H_ACTIVE-1.
- Vertical origin: vcnt=0 is the first active line.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=2); 100 MHz gives 25 MHz pixel rate.
- H_BP, 48, horizontal back porch, in pixels.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk).
- clk_en  output  1  one-clk-wide pulse, every CLK_DIV clks.
- hcnt  output  10  horizontal pixel counter.
- vcnt  output  10  vertical line counter.
- hsync_n  output  1  horizontal sync, active-low.
- vsync_n  output  1  vertical sync, active-low.
- video_on  output  1  high in the active region.
- detect_neg_vsyncb  output  1  frame-start pulse.

Behaviour:
- Derived values:
  - H_TOTAL = H_BP+H_ACTIVE+H_FP+H_SYNC (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be <=1024; a static elaboration check enforces this.
- Reset (rst==0 at a clk edge):
  - div_cnt=0, clk_en=0, hcnt=0, vcnt=0.
  - hsync_n=1, vsync_n=1, video_on=0, detect_neg_vsyncb=0.
  - Reset mid-frame restarts all counters from 0 on the next edge. No partial frame is flagged.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - clk_en is registered and high in exactly the cycle after div_cnt==CLK_DIV-1.
  - First clk_en appears CLK_DIV clks after reset release.
- Horizontal counter (advances only in a clk_en cycle):
  - hcnt counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter:
  - vcnt increments in the same clk_en cycle in which hcnt wraps (799->0).
  - vcnt wraps V_TOTAL-1 -> 0 at the same point.
- Decodes:
  - All decodes are registered, computed from the next-count values, so they change in the same cycle as hcnt/vcnt and stay consistent with them.
  - Horizontal regions: back porch 0..47; active 48..687; front porch 688..703; sync 704..799.
  - hsync_n=0 iff hcnt in [H_BP+H_ACTIVE+H_FP, H_TOTAL-1].
  - Vertical regions: active 0..479; front porch 480..489; sync 490..491; back porch 492..524.
  - vsync_n=0 iff vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - video_on=1 iff hcnt in [H_BP, H_BP+H_ACTIVE-1] and vcnt < V_ACTIVE.
- detect_neg_vsyncb:
  - High iff vcnt==V_ACTIVE+V_FP and hcnt==0, i.e. the first pixel after vsync_n falls.
  - It is held for that whole pixel period (CLK_DIV clks), so it overlaps exactly one clk_en pulse, the one that advances hcnt from 0 to 1.
  - It is never high twice per frame.
- Outputs hold between clk_en pulses.
- Periods: line = H_TOTAL*CLK_DIV clks; frame = V_TOTAL*H_TOTAL*CLK_DIV clks (1,680,000 at defaults).

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt [7:0].
  - Reset value is 0.
  - Increments in the clk_en cycle where detect_neg_vsyncb is high; wraps 255->0.
- When undefined:
  - The port and register are absent.
  - All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_BP, H_ACTIVE, H_FP, H_SYNC, V_ACTIVE, V_FP, V_SYNC, V_BP);
  - the derived H_TOTAL and V_TOTAL;
  - the counter width constant CNT_W=10.
- One sub-module: vga_clk_en_div, which holds div_cnt and produces the registered clk_en (parameter CLK_DIV).
- Counters and decodes stay in the top module.

Test Plan:
- Reset: hold rst=0 for 10 clks, release -> all outputs at reset values; first clk_en at clk 4 after release; clk_en period exactly 4 clks thereafter.
- Line timing:
  - hcnt steps 0..799 over 800 clk_en pulses, then wraps to 0 and vcnt increments.
  - hsync_n low for exactly 96 pixel periods, starting when hcnt becomes 704.
- Frame timing:
  - vsync_n low exactly while vcnt=490..491 (1600 pixels).
  - vcnt wraps 524->0.
  - Consecutive detect_neg_vsyncb pulses are 1,680,000 clks apart, each overlapping exactly one clk_en, at vcnt=490 and hcnt=0.
- video_on:
  - First high at hcnt=48, vcnt=0; last high at hcnt=687, vcnt=479.
  - Count of video_on pixel periods per frame = 307,200.
- Mid-frame reset: drive rst=0 for one clk at vcnt=300, hcnt=500 -> next edge shows hcnt=0, vcnt=0, detect_neg_vsyncb=0, and timing resumes as from power-up.
- VGA_FRAME_CNT_EN defined: run 257 frames -> frame_cnt reaches 255, then 0, then 1; undefined build compiles with no frame_cnt port.
